// File: rtl/seq_detector_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : seq_detector_param_if                                      |
// | Description : Signal bundle for seq_detector_param. The master modport   |
// |               drives the serial stream, enable, load strobe, patterns    |
// |               and mode bit, and reads the results. The slave modport is  |
// |               the detector side.                                         |
// |   w, en, load, overlap      : stream bit, sample enable, load, mode      |
// |   pattern_a, pattern_b      : PAT_LEN-bit patterns, MSB received first   |
// |   z_a, z_b, z               : registered match flags                     |
// |   fill                      : valid history bits (0..PAT_LEN)            |
// |   match_count               : saturating match-event counter             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface seq_detector_param_if #(
  parameter int PAT_LEN = 4,
  parameter int COUNT_W = 8,
  parameter int FILL_W  = $clog2(PAT_LEN + 1)
);
  logic               w;
  logic               en;
  logic               load;
  logic               overlap;
  logic [PAT_LEN-1:0] pattern_a;
  logic [PAT_LEN-1:0] pattern_b;
  logic               z_a;
  logic               z_b;
  logic               z;
  logic [FILL_W-1:0]  fill;
  logic [COUNT_W-1:0] match_count;

  modport master (
    output w, en, load, overlap, pattern_a, pattern_b,
    input  z_a, z_b, z, fill, match_count
  );

  modport slave (
    input  w, en, load, overlap, pattern_a, pattern_b,
    output z_a, z_b, z, fill, match_count
  );
endinterface
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_detector_param                                         |
// | Description : Serial detector for two run-time programmable PAT_LEN-bit  |
// |               patterns with sample enable, overlap/non-overlap mode and  |
// |               an optional saturating match counter.                      |
// | Ports       : clk   - system clock, rising edge                          |
// |               reset - synchronous, active-high                           |
// |               bus   - seq_detector_param_if.slave (stream in, flags out) |
// | Macro       : SEQDET_COUNT_EN - builds the match counter; when undefined |
// |               match_count is tied to zero and no counter flops exist.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seq_detector_param #(
  parameter int PAT_LEN = 4,
  parameter int COUNT_W = 8,
  parameter int FILL_W  = $clog2(PAT_LEN + 1)
) (
  input  wire logic               clk,
  input  wire logic               reset,
  seq_detector_param_if.slave     bus
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  // Only the newest PAT_LEN-1 bits need to be kept: the compare is done on
  // the post-shift window, which adds the incoming bit as its LSB.
  logic [PAT_LEN-2:0] history;
  logic [PAT_LEN-1:0] history_next;
  logic [PAT_LEN-1:0] pat_a_q;
  logic [PAT_LEN-1:0] pat_b_q;
  logic [FILL_W-1:0]  fill_q;
  logic [FILL_W-1:0]  fill_next;
  logic               z_a_q;
  logic               z_b_q;
  logic               hit_a;
  logic               hit_b;

  always_comb begin
    history_next = {history, bus.w};
    fill_next    = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    hit_a        = (fill_next == FILL_FULL) && (history_next == pat_a_q);
    hit_b        = (fill_next == FILL_FULL) && (history_next == pat_b_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      history <= '0;
      fill_q  <= '0;
      z_a_q   <= 1'b0;
      z_b_q   <= 1'b0;
      pat_a_q <= '0;
      pat_b_q <= '0;
    end else if (bus.load) begin
      // The bit presented alongside load is dropped on purpose.
      pat_a_q <= bus.pattern_a;
      pat_b_q <= bus.pattern_b;
      history <= '0;
      fill_q  <= '0;
      z_a_q   <= 1'b0;
      z_b_q   <= 1'b0;
    end else if (bus.en) begin
      history <= history_next[PAT_LEN-2:0];
      // Non-overlap mode restarts the fill count so the next match needs
      // PAT_LEN fresh bits; stale history is masked by fill < PAT_LEN.
      if ((hit_a || hit_b) && !bus.overlap) begin
        fill_q <= '0;
      end else begin
        fill_q <= fill_next;
      end
      z_a_q <= hit_a;
      z_b_q <= hit_b;
    end
  end

`ifdef SEQDET_COUNT_EN
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [COUNT_W-1:0] count_q;

  // A simultaneous A and B hit is one event; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset || bus.load) begin
      count_q <= '0;
    end else if (bus.en && (hit_a || hit_b) && (count_q != COUNT_MAX)) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign bus.match_count = count_q;
`else
  assign bus.match_count = {COUNT_W{1'b0}};
`endif

  assign bus.z_a  = z_a_q;
  assign bus.z_b  = z_b_q;
  assign bus.z    = z_a_q | z_b_q;
  assign bus.fill = fill_q;

endmodule
`default_nettype wire

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern detector; next generation of the team's fixed-pattern binary-encoded Moore detector.
- Watches the 1-bit stream w for either of two run-time-programmable PAT_LEN-bit patterns.
- Adds a sample enable, a selectable overlap/non-overlap mode and a saturating match counter.
- Sits between the synchronised input/debounce logic and the board LEDs/display.

Parameters:
- PAT_LEN, 4, pattern length in bits (2..16).
- COUNT_W, 8, width of match_count.
- FILL_W, $clog2(PAT_LEN+1), width of fill (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- w  input  1  serial data bit; sampled only when en=1.
- en  input  1  sample enable.
- load  input  1  latch pattern_a/pattern_b, clear history.
- pattern_a  input  PAT_LEN  pattern A; MSB is the first bit received.
- pattern_b  input  PAT_LEN  pattern B; MSB is the first bit received.
- overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- z_a  output  1  pattern A matched on the last sampled bit.
- z_b  output  1  pattern B matched on the last sampled bit.
- z  output  1  z_a | z_b.
- fill  output  FILL_W  number of valid history bits, saturating at PAT_LEN; drives the LEDs.
- match_count  output  COUNT_W  match events since reset/load.

Behaviour:
Reset:
- Synchronous active-high reset clears: history, fill, z_a, z_b, match_count, pat_a_q, pat_b_q.
- All outputs read 0 the cycle after reset is sampled high.
- Reset takes priority over load and en.

Load:
- When load=1 and reset=0: pat_a_q <= pattern_a and pat_b_q <= pattern_b.
- history, fill, z_a, z_b and match_count are cleared.
- Any bit sampled in the same cycle is discarded.

Sampling (en=1, load=0):
- history <= {history[PAT_LEN-2:0], w}.
- fill <= min(fill+1, PAT_LEN).

Match evaluation:
- Computed on the post-shift history and post-increment fill in the same edge.
- hit_a = (fill_next == PAT_LEN) && (history_next == pat_a_q); hit_b is the same against pat_b_q.
- z_a <= hit_a and z_b <= hit_b (registered, Moore).
- Latency: z rises one clock after the edge that samples the final pattern bit.
- z holds until the next sampled bit.

Holding (en=0, load=0):
- All state and outputs hold, including z; no new matches are detected.

Overlap modes:
- overlap=1: the history is untouched after a match. Consecutive samples can match, e.g. all-zeros pattern on a zero run matches every bit once fill=PAT_LEN.
- overlap=0: if hit_a|hit_b, fill <= 0. The next match needs PAT_LEN fresh bits; the history contents are irrelevant while fill<PAT_LEN.
- overlap is sampled every cycle; changing it mid-stream affects only subsequent edges.

Simultaneous matches:
- If pat_a_q == pat_b_q, or both match, then z_a=z_b=1.
- A simultaneous A and B hit counts as one match event.

Counter:
- match_count increments by 1 on each edge where hit_a|hit_b.
- Saturates at 2^COUNT_W-1; no wrap.

Widths: all comparisons are full PAT_LEN bits; there are no partial/wildcard bits.

Optional Feature:
Macro: SEQDET_COUNT_EN
- Defined: the match_count register and saturating increment are built as specified.
- Undefined: no counter flops; match_count is tied to 0. All other behaviour is unchanged.

Test Plan:
All scenarios use PAT_LEN=4, COUNT_W=8, pattern_a=4'b1011, pattern_b=4'b0000, loaded via load; en=1 unless stated.
- Reset check: hold reset 2 cycles mid-stream -> z_a=z_b=z=0, fill=0, match_count=0 the cycle after.
- Basic match: w=1,0,1,1 -> fill=1,2,3,4; z_a=1 only in the cycle after the 4th bit; z_b=0; match_count=1.
- Overlap mode, pattern A, w=1,0,1,1,0,1,1:
  - overlap=1 -> z_a after bits 4 and 7, match_count=2.
  - overlap=0 -> z_a after bit 4 only, fill=3 after bit 7, match_count=1.
- Overlap mode, zero run of 6 zeros:
  - overlap=1 -> z_b after bits 4, 5 and 6, match_count=3.
  - overlap=0 -> z_b after bit 4 only, fill=2 at end.
- Enable gaps and load:
  - Pattern 1,0,1,1 with en=0 gaps of 3 cycles between bits -> same z_a result; all outputs hold during gaps.
  - load asserted with en=1 after bits 1,0,1 -> that bit discarded, fill=0, count=0; a fresh 1,0,1,1 still matches.
- Saturation and macro:
  - COUNT_W=2 with SEQDET_COUNT_EN defined, 5 overlapping zero matches -> match_count sticks at 3.
  - Same run without the macro -> match_count=0 throughout, z behaviour identical.
